// File: rtl/pbi_cycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pbi_pkg
//  Purpose  : Shared types, constants and helpers for the PBI cycle controller.
//             FSM state encoding, bus-cycle classification, fixed PBI
//             register/window addresses, saturating counter helper.
//  Revision : 1.0  initial release
// ============================================================================
package pbi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_DRIVE  = 3'd4,
        ST_WFALL  = 3'd5
    } pbi_state_t;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_REG  = 2'd1,
        CLS_ROM  = 2'd2,
        CLS_IO   = 2'd3
    } pbi_class_t;

    localparam logic [15:0] ADDR_DEVSEL = 16'hD1FF;
    localparam logic [15:0] ADDR_IRQCLR = 16'hD1FE;
    localparam logic [15:0] ROM_LO      = 16'hD800;
    localparam logic [15:0] ROM_HI      = 16'hDFFF;

    // Register hits are decoded regardless of dev_en so the host can always
    // enable the device; the ROM window and D1xx I/O only belong to us once
    // enabled.
    function automatic pbi_class_t classify(input logic [15:0] addr,
                                            input logic        dev_en,
                                            input logic        d1xx_n);
        pbi_class_t cls;
        cls = CLS_NONE;
        if (addr == ADDR_DEVSEL || addr == ADDR_IRQCLR)
            cls = CLS_REG;
        else if (dev_en && addr >= ROM_LO && addr <= ROM_HI)
            cls = CLS_ROM;
        else if (dev_en && !d1xx_n)
            cls = CLS_IO;
        return cls;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pbi_cycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pbi_cycle_ctrl_if
//  Purpose  : Internal memory port between the PBI cycle controller (master)
//             and the shared ROM/RAM arbiter (slave).
//  Signals  : mem_req/mem_we/mem_addr/mem_wdata  master -> slave
//             mem_ack (1-clk pulse)/mem_rdata    slave  -> master
//  Revision : 1.0  initial release
// ============================================================================
interface pbi_cycle_ctrl_if #(
    parameter int MEM_AW = 12
);
    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/pbi_cycle_ctrl_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module   : pbi_edge_sync
//  Purpose  : Brings the asynchronous bus phi2 into the clk domain and
//             produces single-clk rise/fall pulses (2-3 clk after the edge).
//  Ports    : clk, rst        system clock, async active-high reset
//             bus_clk         raw phi2
//             rise, fall      1-clk pulses on the synchronised edges
//  Revision : 1.0  initial release
// ============================================================================
module pbi_edge_sync (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic bus_clk,
    output logic      rise,
    output logic      fall
);
    logic r_meta;
    logic r_sync;
    logic r_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_meta <= bus_clk;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign rise = r_sync & ~r_hist;
    assign fall = ~r_sync & r_hist;
endmodule
`default_nettype wire

// File: rtl/pbi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pbi_cycle_ctrl
//  Purpose  : Atari PBI device cycle sequencer. Oversamples phi2, decodes
//             each bus cycle, owns the D1FF device-select register and the
//             IRQ pending bit, and bridges ROM/IO reads and writes onto the
//             internal memory port.
//  Ports    : clk, rst                     system clock, async reset
//             bus_clk, rw_n, addr, data_in, D1xx_n   PBI bus inputs
//             data_out, data_oe            pin buffer data / drive enable
//             mpd_n, extsel_n, irq_n_oe    PBI control outputs
//             irq_src                      IRQ request pulse from the core
//             dev_en, err_cnt              status
//             mem_if                       memory port (master side)
//  Revision : 1.0  initial release
// ============================================================================
module pbi_cycle_ctrl
    import pbi_pkg::*;
#(
    parameter int DEV_BIT   = 0,
    parameter int SETUP_CYC = 4,
    parameter int MEM_AW    = 12
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        bus_clk,
    input  wire logic        rw_n,
    input  wire logic [15:0] addr,
    input  wire logic [7:0]  data_in,
    input  wire logic        D1xx_n,
    input  wire logic        irq_src,
    output logic      [7:0]  data_out,
    output logic             data_oe,
    output logic             mpd_n,
    output logic             extsel_n,
    output logic             irq_n_oe,
    output logic             dev_en,
    output logic      [7:0]  err_cnt,
    pbi_cycle_ctrl_if.master mem_if
);
    localparam logic [3:0] C_SETUP_LOAD = 4'(SETUP_CYC - 1);

    logic w_rise;
    logic w_fall;

    pbi_edge_sync u_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .bus_clk (bus_clk),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    pbi_state_t        r_state,      w_state_nxt;
    pbi_class_t        r_cls,        w_cls_nxt;
    pbi_class_t        w_cls;
    logic [3:0]        r_cnt,        w_cnt_nxt;
    logic [15:0]       r_lat_addr,   w_lat_addr_nxt;
    logic              r_lat_rw_n,   w_lat_rw_n_nxt;
    logic              r_lat_d1xx_n, w_lat_d1xx_n_nxt;
    logic [7:0]        r_data_out,   w_data_out_nxt;
    logic              r_data_oe,    w_data_oe_nxt;
    logic              r_extsel_n,   w_extsel_n_nxt;
    logic              r_mem_req,    w_mem_req_nxt;
    logic              r_mem_we,     w_mem_we_nxt;
    logic [MEM_AW-1:0] r_mem_addr,   w_mem_addr_nxt;
    logic [7:0]        r_mem_wdata,  w_mem_wdata_nxt;
    logic [7:0]        r_hold,       w_hold_nxt;
    logic              r_dev_en,     w_dev_en_nxt;
    logic              r_pending,    w_pending_nxt;
    logic [7:0]        r_err_cnt,    w_err_cnt_nxt;
    logic              w_irq_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cls        <= CLS_NONE;
            r_cnt        <= 4'd0;
            r_lat_addr   <= 16'd0;
            r_lat_rw_n   <= 1'b1;
            r_lat_d1xx_n <= 1'b1;
            r_data_out   <= 8'd0;
            r_data_oe    <= 1'b0;
            r_extsel_n   <= 1'b1;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 8'd0;
            r_hold       <= 8'd0;
            r_dev_en     <= 1'b0;
            r_pending    <= 1'b0;
            r_err_cnt    <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_cls        <= w_cls_nxt;
            r_cnt        <= w_cnt_nxt;
            r_lat_addr   <= w_lat_addr_nxt;
            r_lat_rw_n   <= w_lat_rw_n_nxt;
            r_lat_d1xx_n <= w_lat_d1xx_n_nxt;
            r_data_out   <= w_data_out_nxt;
            r_data_oe    <= w_data_oe_nxt;
            r_extsel_n   <= w_extsel_n_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_hold       <= w_hold_nxt;
            r_dev_en     <= w_dev_en_nxt;
            r_pending    <= w_pending_nxt;
            r_err_cnt    <= w_err_cnt_nxt;
        end
    end

    assign w_cls = classify(r_lat_addr, r_dev_en, r_lat_d1xx_n);

    always_comb begin
        w_state_nxt      = r_state;
        w_cls_nxt        = r_cls;
        w_cnt_nxt        = r_cnt;
        w_lat_addr_nxt   = r_lat_addr;
        w_lat_rw_n_nxt   = r_lat_rw_n;
        w_lat_d1xx_n_nxt = r_lat_d1xx_n;
        w_data_out_nxt   = r_data_out;
        w_data_oe_nxt    = r_data_oe;
        w_extsel_n_nxt   = r_extsel_n;
        // Request strobes are re-asserted explicitly every clk they must stay
        // high; a write commit therefore lasts exactly one clk.
        w_mem_req_nxt    = 1'b0;
        w_mem_we_nxt     = 1'b0;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_hold_nxt       = r_hold;
        w_dev_en_nxt     = r_dev_en;
        w_err_cnt_nxt    = r_err_cnt;
        w_irq_clr        = 1'b0;

        if (w_rise && r_state != ST_IDLE) begin
            // The previous cycle's fall was missed: abandon it and resync.
            w_state_nxt    = ST_SETUP;
            w_cnt_nxt      = C_SETUP_LOAD;
            w_data_oe_nxt  = 1'b0;
            w_extsel_n_nxt = 1'b1;
            w_err_cnt_nxt  = sat_inc8(r_err_cnt);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = ST_SETUP;
                        w_cnt_nxt   = C_SETUP_LOAD;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == 4'd0) begin
                        w_lat_addr_nxt   = addr;
                        w_lat_rw_n_nxt   = rw_n;
                        w_lat_d1xx_n_nxt = D1xx_n;
                        w_state_nxt      = ST_DECODE;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                ST_DECODE: begin
                    w_cls_nxt = w_cls;
                    if (w_cls == CLS_ROM || w_cls == CLS_IO)
                        w_extsel_n_nxt = 1'b0;
                    if (w_cls == CLS_REG && r_lat_rw_n) begin
                        w_data_out_nxt = (r_lat_addr == ADDR_DEVSEL)
                                       ? (8'(r_pending) << DEV_BIT) : 8'h00;
                        w_data_oe_nxt  = 1'b1;
                        w_state_nxt    = ST_DRIVE;
                    end else if ((w_cls == CLS_ROM || w_cls == CLS_IO) && r_lat_rw_n) begin
                        w_mem_req_nxt  = 1'b1;
                        w_mem_addr_nxt = r_lat_addr[MEM_AW-1:0];
                        w_state_nxt    = ST_MEM;
                    end else begin
                        w_state_nxt = ST_WFALL;
                    end
                end
                ST_MEM: begin
                    // A fall with no data in hand is a missed deadline; the
                    // pin buffer is never enabled for this cycle.
                    if (w_fall) begin
                        w_err_cnt_nxt  = sat_inc8(r_err_cnt);
                        w_extsel_n_nxt = 1'b1;
                        w_state_nxt    = ST_IDLE;
                    end else if (mem_if.mem_ack) begin
                        w_data_out_nxt = mem_if.mem_rdata;
                        w_data_oe_nxt  = 1'b1;
                        w_state_nxt    = ST_DRIVE;
                    end else begin
                        w_mem_req_nxt = 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (w_fall) begin
                        w_data_oe_nxt  = 1'b0;
                        w_extsel_n_nxt = 1'b1;
                        w_state_nxt    = ST_IDLE;
                    end
                end
                ST_WFALL: begin
                    // Commit uses the byte shadowed before the fall pulse,
                    // since the host may release the bus right after phi2 falls.
                    w_hold_nxt = data_in;
                    if (w_fall) begin
                        w_extsel_n_nxt = 1'b1;
                        w_state_nxt    = ST_IDLE;
                        if (!r_lat_rw_n) begin
                            if (r_cls == CLS_REG) begin
                                if (r_lat_addr == ADDR_DEVSEL)
                                    w_dev_en_nxt = r_hold[DEV_BIT];
                                else
                                    w_irq_clr = 1'b1;
                            end else if (r_cls == CLS_ROM || r_cls == CLS_IO) begin
                                w_mem_req_nxt   = 1'b1;
                                w_mem_we_nxt    = 1'b1;
                                w_mem_addr_nxt  = r_lat_addr[MEM_AW-1:0];
                                w_mem_wdata_nxt = r_hold;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // A new request in the same clk as a clear must not be lost.
    assign w_pending_nxt = irq_src | (r_pending & ~w_irq_clr);

    assign data_out         = r_data_out;
    assign data_oe          = r_data_oe;
    assign mpd_n            = ~r_dev_en;
    assign extsel_n         = r_extsel_n;
    assign irq_n_oe         = r_pending & r_dev_en;
    assign dev_en           = r_dev_en;
    assign err_cnt          = r_err_cnt;
    assign mem_if.mem_req   = r_mem_req;
    assign mem_if.mem_we    = r_mem_we;
    assign mem_if.mem_addr  = r_mem_addr;
    assign mem_if.mem_wdata = r_mem_wdata;
endmodule
`default_nettype wire

// File: doc/pbi_cycle_ctrl.md
Name: pbi_cycle_ctrl

Overview:
- Sequences Atari Parallel Bus Interface (PBI) device cycles, running on a fast system clock and oversampling the asynchronous bus phi2 (`bus_clk`).
- Owns the D1FF device-select register. When the device is enabled, it drives `mpd_n` and `extsel_n` for the D800–DFFF ROM window, and bridges bus reads and writes to an internal memory port with a req/ack handshake.
- Generates the PBI IRQ and sits between the bus pin buffers and the shared ROM/RAM arbiter.

Parameters:
- DEV_BIT, 0, bit of the D1FF data byte that selects this device; also the IRQ status bit position. Range 0–7.
- SETUP_CYC, 4, system clocks to wait after the synchronised phi2 rise before sampling addr/rw_n. Range 1–15.
- MEM_AW, 12, memory port address width; low MEM_AW bits of the bus address.

Ports:
- clk  in  1  system clock, at least 8x bus phi2
- rst  in  1  asynchronous reset, active-high
- bus_clk  in  1  Atari phi2, asynchronous to clk
- rw_n  in  1  bus read/write_n
- addr  in  16  bus address
- data_in  in  8  bus data from pin buffer
- D1xx_n  in  1  D1xx page select from host
- irq_src  in  1  single-clk pulse from the device core requesting an interrupt
- data_out  out  8  data for the pin buffer
- data_oe  out  1  pin buffer drive enable
- mpd_n  out  1  math-pack disable, active-low
- extsel_n  out  1  external select, active-low
- irq_n_oe  out  1  open-drain IRQ drive; 1 pulls `irq_n` low
- dev_en  out  1  device-enabled status
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  MEM_AW  memory address
- mem_wdata  out  8  memory write data
- mem_ack  in  1  memory ack, single-clk pulse
- mem_rdata  in  8  read data, valid with mem_ack
- err_cnt  out  8  saturating count of missed memory deadlines

Behaviour:
- Reset values: all outputs 0 except `mpd_n`=1 and `extsel_n`=1. `dev_en`=0, IRQ pending=0, `err_cnt`=0, FSM=IDLE.
- Reset is asynchronous. Asserting it mid-cycle releases `data_oe` and `mem_req` immediately.
- `bus_clk` passes through a 2-flop synchroniser plus a history flop.
- `rise` is a single-clk pulse on 0->1 of the synchronised signal; `fall` is a single-clk pulse on 1->0.
- Latency from a phi2 edge to its pulse is 2–3 clk.
- `mpd_n` = ~dev_en, combinational from the register.
- FSM states: IDLE, SETUP, DECODE, MEM, DRIVE, WFALL.
  - IDLE: on `rise` -> SETUP, with the counter loaded to SETUP_CYC-1.
  - SETUP: count down; at 0 latch addr, rw_n and D1xx_n -> DECODE.
  - DECODE (one clk): classify the latched cycle.
    - REG: addr==D1FF or D1FE.
    - ROM: dev_en && addr in D800–DFFF.
    - IO: dev_en && D1xx_n==0, not REG.
    - NONE: anything else -> WFALL.
  - Read of D1FF: `data_out` = pending<<DEV_BIT -> DRIVE.
  - Read of D1FE: `data_out` = 0x00 -> DRIVE.
  - REG write: -> WFALL.
  - ROM/IO read: assert `mem_req`, `mem_we`=0, `mem_addr`=addr[MEM_AW-1:0] -> MEM.
  - ROM/IO write: -> WFALL.
  - `extsel_n`=0 from DECODE until `fall` when class is ROM or IO.
  - MEM: on `mem_ack`, drop `mem_req`, capture `mem_rdata` into `data_out` -> DRIVE. If `fall` arrives first: drop `mem_req`, increment `err_cnt` (saturating at 255), leave `data_oe`=0 -> IDLE.
    - A `mem_ack` that arrives after the abort is ignored.
  - DRIVE: `data_oe`=1 until `fall`, then `data_oe`=0 -> IDLE.
  - WFALL: each clk, shadow `data_in` into a holding register.
    - On `fall`, write cycles commit using the value captured before `fall`.
    - D1FF write: dev_en = data[DEV_BIT].
    - D1FE write: clear pending.
    - ROM/IO write: pulse `mem_req`+`mem_we` with `mem_wdata`=held byte for one clk.
    - Go to IDLE. Write acks do not gate the FSM; late acks are ignored.
- A `rise` seen outside IDLE (a missed `fall`) forces a restart into SETUP and increments `err_cnt`.
- `irq_src` sets pending.
  - If set and clear occur on the same clk, the set wins.
  - `irq_n_oe` = pending & dev_en.

Decomposition:
- Package `pbi_pkg`:
  - FSM state enum.
  - Cycle class enum (NONE/REG/ROM/IO).
  - Constants: ADDR_DEVSEL=16'hD1FF, ADDR_IRQCLR=16'hD1FE, ROM_LO=16'hD800, ROM_HI=16'hDFFF.
- Sub-module `pbi_edge_sync`: the synchroniser and rise/fall pulse generator.

Test Plan:
- Reset, then a phi2 at 1.79 MHz on a 100 MHz clk with a write of 0x01 to D1FF (DEV_BIT=0) -> `dev_en`=1 and `mpd_n`=0 after `fall`. A write of 0x02 -> `dev_en`=0.
- dev_en=1, read of $D812, memory acks after 5 clk with 0xA5 -> `mem_addr`=0x812, `extsel_n` low, `data_oe`=1 and `data_out`=0xA5 until `fall`.
- Same read with no ack -> `mem_req` drops at `fall`, `err_cnt`=1, `data_oe` never asserted. An ack one clk later causes no change.
- `irq_src` pulse with dev_en=1 -> `irq_n_oe`=1. A read of D1FF returns 0x01. A write to D1FE clears it. A simultaneous `irq_src` and D1FE commit leaves pending set.
- dev_en=0, read of $D900 -> class NONE, `extsel_n`=1, `data_oe`=0, no `mem_req`.
- `rst` asserted while in MEM -> `mem_req`, `data_oe` and `dev_en` are 0 in the same clk. The next bus cycle decodes normally.
